ic_rep_arbiter: RTL and testbench

IC_REP_ARBITER -- requirements
Module: ic_rep_arbiter

---
 rtl/ic_rep_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ic_rep_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ic_rep_arbiter.sv
// Arbitrates inst-line transfers between local memory lines and network replies toward ic_download.
// Define IC_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise memory always wins a tie.
module ic_rep_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] mem_flits_in,
    input  logic         v_mem_flits_in,
    output logic         mem_ack,
    input  logic [15:0]  rep_flit_in,
    input  logic         v_rep_flit_in,
    input  logic [1:0]   rep_ctrl_in,
    output logic         rep_flit_pop,
    input  logic         ic_download_state,
    output logic [127:0] mem_flits_ic,
    output logic         v_mem_flits_ic,
    output logic [15:0]  rep_flit_ic,
    output logic         v_rep_flit_ic,
    output logic [1:0]   rep_ctrl_ic,
    output logic [1:0]   arb_state,
    output logic         err_proto
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        NET   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_BODY = 2'b10;
    localparam logic [1:0] CTRL_TAIL = 2'b11;
    // Head plus seven bodies have been forwarded when the count reaches this value.
    localparam logic [3:0] LAST_CNT  = 4'd8;

    state_t     state, state_nx;
    logic [3:0] flit_cnt, flit_cnt_nx;
    logic       drain_seen, drain_seen_nx;
    logic       grant_mem, grant_net;
    logic       pop, fwd, set_err;
    logic [1:0] fwd_ctrl;
    logic       mem_req, net_req, mem_first;

    assign mem_req = v_mem_flits_in;
    assign net_req = v_rep_flit_in && (rep_ctrl_in == CTRL_HEAD);

`ifdef IC_ARB_ROUND_ROBIN_EN
    logic last_grant_mem;

    always_ff @(posedge clk) begin
        if (rst)
            last_grant_mem <= 1'b0;
        else if (grant_mem)
            last_grant_mem <= 1'b1;
        else if (grant_net)
            last_grant_mem <= 1'b0;
    end

    assign mem_first = ~last_grant_mem;
`else
    assign mem_first = 1'b1;
`endif

    always_comb begin
        state_nx      = state;
        flit_cnt_nx   = flit_cnt;
        drain_seen_nx = drain_seen;
        grant_mem     = 1'b0;
        grant_net     = 1'b0;
        pop           = 1'b0;
        fwd           = 1'b0;
        fwd_ctrl      = rep_ctrl_in;
        set_err       = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (!ic_download_state) begin
                        if (mem_req && (!net_req || mem_first)) begin
                            grant_mem     = 1'b1;
                            state_nx      = DRAIN;
                            drain_seen_nx = 1'b0;
                        end else if (net_req) begin
                            grant_net   = 1'b1;
                            pop         = 1'b1;
                            fwd         = 1'b1;
                            flit_cnt_nx = 4'd1;
                            state_nx    = NET;
                        end else if (v_rep_flit_in) begin
                            // Orphan flit (e.g. rest of a packet cut by reset): discard to resync.
                            pop     = 1'b1;
                            set_err = 1'b1;
                        end
                    end
                end
                NET: begin
                    if (v_rep_flit_in) begin
                        pop = 1'b1;
                        case (rep_ctrl_in)
                            CTRL_BODY: begin
                                fwd = 1'b1;
                                if (flit_cnt == LAST_CNT) begin
                                    fwd_ctrl      = CTRL_TAIL;
                                    set_err       = 1'b1;
                                    state_nx      = DRAIN;
                                    drain_seen_nx = 1'b0;
                                end else begin
                                    flit_cnt_nx = flit_cnt + 4'd1;
                                end
                            end
                            CTRL_TAIL: begin
                                fwd           = 1'b1;
                                flit_cnt_nx   = flit_cnt + 4'd1;
                                set_err       = (flit_cnt != LAST_CNT);
                                state_nx      = DRAIN;
                                drain_seen_nx = 1'b0;
                            end
                            default: set_err = 1'b1;
                        endcase
                    end
                end
                DRAIN: begin
                    if (drain_seen && !ic_download_state)
                        state_nx = IDLE;
                    else
                        drain_seen_nx = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign mem_ack      = grant_mem;
    assign rep_flit_pop = pop;
    assign arb_state    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            flit_cnt       <= 4'd0;
            drain_seen     <= 1'b0;
            v_mem_flits_ic <= 1'b0;
            v_rep_flit_ic  <= 1'b0;
            mem_flits_ic   <= '0;
            rep_flit_ic    <= '0;
            rep_ctrl_ic    <= '0;
            err_proto      <= 1'b0;
        end else begin
            state          <= state_nx;
            flit_cnt       <= flit_cnt_nx;
            drain_seen     <= drain_seen_nx;
            v_mem_flits_ic <= grant_mem;
            v_rep_flit_ic  <= fwd;
            if (grant_mem)
                mem_flits_ic <= mem_flits_in;
            if (fwd) begin
                rep_flit_ic <= rep_flit_in;
                rep_ctrl_ic <= fwd_ctrl;
            end
            err_proto <= err_proto | set_err;
        end
    end

endmodule

// File: tb/tb_ic_rep_arbiter.sv
// Self-checking bench for ic_rep_arbiter: queue-driven sources and a behavioural reference model.
module tb_ic_rep_arbiter;

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [15:0] data;
    } flit_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] mem_flits_in;
    logic         v_mem_flits_in;
    logic         mem_ack;
    logic [15:0]  rep_flit_in;
    logic         v_rep_flit_in;
    logic [1:0]   rep_ctrl_in;
    logic         rep_flit_pop;
    logic         ic_download_state;
    logic [127:0] mem_flits_ic;
    logic         v_mem_flits_ic;
    logic [15:0]  rep_flit_ic;
    logic         v_rep_flit_ic;
    logic [1:0]   rep_ctrl_ic;
    logic [1:0]   arb_state;
    logic         err_proto;

    ic_rep_arbiter dut (
        .clk(clk), .rst(rst),
        .mem_flits_in(mem_flits_in), .v_mem_flits_in(v_mem_flits_in), .mem_ack(mem_ack),
        .rep_flit_in(rep_flit_in), .v_rep_flit_in(v_rep_flit_in), .rep_ctrl_in(rep_ctrl_in),
        .rep_flit_pop(rep_flit_pop), .ic_download_state(ic_download_state),
        .mem_flits_ic(mem_flits_ic), .v_mem_flits_ic(v_mem_flits_ic),
        .rep_flit_ic(rep_flit_ic), .v_rep_flit_ic(v_rep_flit_ic), .rep_ctrl_ic(rep_ctrl_ic),
        .arb_state(arb_state), .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Sources: reply fifo contents and pending memory lines.
    flit_t        rq[$];
    logic [127:0] mq[$];
    bit           busy, gap;

    // Reference model: mode 0 idle, 1 in packet, 2 draining.
    int           m_mode, m_cnt, m_drain;
    bit           m_err, m_last_mem, m_vmem, m_vrep;
    logic [127:0] m_mline;
    logic [15:0]  m_rflit;
    logic [1:0]   m_rctrl;
    int           n_mode, n_cnt, n_drain;
    bit           n_err, n_last_mem, n_vmem, n_vrep;
    logic [127:0] n_mline;
    logic [15:0]  n_rflit;
    logic [1:0]   n_rctrl;
    bit           e_ack, e_pop;

    task automatic push_good_packet(input logic [15:0] hd);
        rq.push_back({2'b01, hd});
        for (int k = 0; k < 7; k++) rq.push_back({2'b10, 16'($urandom)});
        rq.push_back({2'b11, 16'($urandom)});
    endtask

    task automatic drive_inputs();
        v_mem_flits_in    = (mq.size() > 0);
        mem_flits_in      = (mq.size() > 0) ? mq[0] : '0;
        v_rep_flit_in     = (rq.size() > 0) && !gap;
        rep_flit_in       = (rq.size() > 0) ? rq[0].data : '0;
        rep_ctrl_in       = (rq.size() > 0) ? rq[0].ctrl : 2'b00;
        ic_download_state = busy;
    endtask

    task automatic model_eval();
        bit head, mem_wins;
        n_mode = m_mode; n_cnt = m_cnt; n_drain = m_drain; n_err = m_err;
        n_last_mem = m_last_mem; n_mline = m_mline; n_rflit = m_rflit; n_rctrl = m_rctrl;
        n_vmem = 0; n_vrep = 0; e_ack = 0; e_pop = 0;
        if (rst) begin
            n_mode = 0; n_cnt = 0; n_drain = 0; n_err = 0; n_last_mem = 0;
            n_mline = '0; n_rflit = '0; n_rctrl = '0;
        end else if (m_mode == 0) begin
            if (!busy) begin
                head = v_rep_flit_in && rep_ctrl_in == 2'b01;
`ifdef IC_ARB_ROUND_ROBIN_EN
                mem_wins = !m_last_mem;
`else
                mem_wins = 1'b1;
`endif
                if (v_mem_flits_in && (!head || mem_wins)) begin
                    e_ack = 1; n_vmem = 1; n_mline = mem_flits_in;
                    n_mode = 2; n_drain = 0; n_last_mem = 1;
                end else if (head) begin
                    e_pop = 1; n_vrep = 1; n_rflit = rep_flit_in; n_rctrl = 2'b01;
                    n_cnt = 1; n_mode = 1; n_last_mem = 0;
                end else if (v_rep_flit_in) begin
                    e_pop = 1; n_err = 1;
                end
            end
        end else if (m_mode == 1) begin
            if (v_rep_flit_in) begin
                e_pop = 1;
                if (rep_ctrl_in == 2'b10 && m_cnt < 8) begin
                    n_vrep = 1; n_rflit = rep_flit_in; n_rctrl = 2'b10; n_cnt = m_cnt + 1;
                end else if (rep_ctrl_in == 2'b10) begin
                    n_vrep = 1; n_rflit = rep_flit_in; n_rctrl = 2'b11;
                    n_err = 1; n_mode = 2; n_drain = 0;
                end else if (rep_ctrl_in == 2'b11) begin
                    n_vrep = 1; n_rflit = rep_flit_in; n_rctrl = 2'b11;
                    if (m_cnt != 8) n_err = 1;
                    n_mode = 2; n_drain = 0;
                end else begin
                    n_err = 1;
                end
            end
        end else begin
            if (m_drain + 1 >= 2 && !busy) n_mode = 0;
            else n_drain = m_drain + 1;
        end
    endtask

    function automatic logic [152:0] obs();
        return {mem_ack, rep_flit_pop, arb_state, v_mem_flits_ic, v_rep_flit_ic,
                rep_ctrl_ic, rep_flit_ic, err_proto, mem_flits_ic};
    endfunction

    function automatic logic [152:0] exp_obs();
        return {e_ack, e_pop, 2'(m_mode), m_vmem, m_vrep, m_rctrl, m_rflit, m_err, m_mline};
    endfunction

    task automatic end_cycle();
        m_mode = n_mode; m_cnt = n_cnt; m_drain = n_drain; m_err = n_err;
        m_last_mem = n_last_mem; m_vmem = n_vmem; m_vrep = n_vrep;
        m_mline = n_mline; m_rflit = n_rflit; m_rctrl = n_rctrl;
        if (e_pop && rq.size() > 0) void'(rq.pop_front());
        if (e_ack && mq.size() > 0) void'(mq.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 18; i++) begin
            rst = (i < 2); busy = 0; gap = 0;
            if (i == 0) begin
                rq.delete(); mq.delete();
                mq.push_back({4{32'hdead_beef}});
                push_good_packet(16'h0abc);
            end
            drive_inputs();
            @(negedge clk);
            model_eval();
            if (i == 0) begin
                total++;
                if ({mem_ack, rep_flit_pop} !== 2'b00)
                    $display("FAIL reset_comb: ack/pop=%b want 00", {mem_ack, rep_flit_pop});
                else passed++;
            end else begin
                total++;
                if (obs() !== exp_obs())
                    $display("FAIL reset cyc %0d: got %h want %h", i, obs(), exp_obs());
                else passed++;
            end
            if (i == 2) begin
                total++;
                if ({arb_state, v_mem_flits_ic, v_rep_flit_ic, rep_ctrl_ic, rep_flit_ic, err_proto, mem_flits_ic} !== '0)
                    $display("FAIL reset_state: outputs not all zero, state=%b err=%b", arb_state, err_proto);
                else passed++;
            end
            end_cycle();
        end
    endtask

    task automatic test_mem_line();
        logic [127:0] line;
        line = {4{32'h1234_5678}};
        for (int i = 0; i < 6; i++) begin
            rst = (i == 0); busy = 0; gap = 0;
            if (i == 0) begin rq.delete(); mq.delete(); end
            if (i == 1) mq.push_back(line);
            drive_inputs();
            @(negedge clk);
            model_eval();
            total++;
            if (obs() !== exp_obs())
                $display("FAIL mem_line cyc %0d: got %h want %h", i, obs(), exp_obs());
            else passed++;
            if (i == 1) begin
                total++;
                if (mem_ack !== 1'b1) $display("FAIL mem_ack: got %b want 1", mem_ack);
                else passed++;
            end
            if (i == 2) begin
                total++;
                if ({v_mem_flits_ic, mem_flits_ic, arb_state} !== {1'b1, line, 2'b10})
                    $display("FAIL mem_fwd: v=%b line=%h st=%b want 1 %h 10", v_mem_flits_ic, mem_flits_ic, arb_state, line);
                else passed++;
            end
            if (i == 4) begin
                total++;
                if (arb_state !== 2'b00) $display("FAIL mem_drain_exit: state=%b want 00", arb_state);
                else passed++;
            end
            end_cycle();
        end
    endtask

    task automatic test_packet();
        int pops;
        pops = 0;
        for (int i = 0; i < 14; i++) begin
            rst = (i == 0); busy = 0; gap = 0;
            if (i == 0) begin rq.delete(); mq.delete(); end
            if (i == 1) push_good_packet(16'h1234);
            drive_inputs();
            @(negedge clk);
            model_eval();
            if (rep_flit_pop === 1'b1) pops++;
            total++;
            if (obs() !== exp_obs())
                $display("FAIL packet cyc %0d: got %h want %h", i, obs(), exp_obs());
            else passed++;
            if (i == 2) begin
                total++;
                if ({v_rep_flit_ic, rep_ctrl_ic, rep_flit_ic, arb_state} !== {1'b1, 2'b01, 16'h1234, 2'b01})
                    $display("FAIL packet_head: v=%b ctrl=%b flit=%h st=%b", v_rep_flit_ic, rep_ctrl_ic, rep_flit_ic, arb_state);
                else passed++;
            end
            if (i == 10) begin
                total++;
                if ({v_rep_flit_ic, rep_ctrl_ic, arb_state, err_proto} !== {1'b1, 2'b11, 2'b10, 1'b0})
                    $display("FAIL packet_tail: v=%b ctrl=%b st=%b err=%b want 1 11 10 0", v_rep_flit_ic, rep_ctrl_ic, arb_state, err_proto);
                else passed++;
            end
            end_cycle();
        end
        total++;
        if (pops != 9) $display("FAIL packet_pops: got %0d want 9", pops);
        else passed++;
    endtask

    task automatic test_tie();
        logic [1:0] second;
`ifdef IC_ARB_ROUND_ROBIN_EN
        second = 2'b01;
`else
        second = 2'b10;
`endif
        for (int i = 0; i < 26; i++) begin
            rst = (i == 0); busy = 0; gap = 0;
            if (i == 0) begin rq.delete(); mq.delete(); end
            if (i == 1) begin
                mq.push_back({4{32'h1111_2222}});
                mq.push_back({4{32'h3333_4444}});
                push_good_packet(16'h5a5a);
            end
            drive_inputs();
            @(negedge clk);
            model_eval();
            total++;
            if (obs() !== exp_obs())
                $display("FAIL tie cyc %0d: got %h want %h", i, obs(), exp_obs());
            else passed++;
            if (i == 1 || i == 2 || i == 3) begin
                total++;
                if ({mem_ack, rep_flit_pop} !== ((i == 1) ? 2'b10 : 2'b00))
                    $display("FAIL tie_first cyc %0d: ack/pop=%b", i, {mem_ack, rep_flit_pop});
                else passed++;
            end
            if (i == 4) begin
                total++;
                if ({mem_ack, rep_flit_pop} !== second)
                    $display("FAIL tie_second: ack/pop=%b want %b", {mem_ack, rep_flit_pop}, second);
                else passed++;
            end
            end_cycle();
        end
    endtask

    task automatic test_busy();
        for (int i = 0; i < 24; i++) begin
            rst = (i == 0); busy = (i >= 1 && i <= 5); gap = 0;
            if (i == 0) begin rq.delete(); mq.delete(); end
            if (i == 1) begin
                mq.push_back({4{32'hcafe_f00d}});
                push_good_packet(16'h7777);
            end
            drive_inputs();
            @(negedge clk);
            model_eval();
            total++;
            if (obs() !== exp_obs())
                $display("FAIL busy cyc %0d: got %h want %h", i, obs(), exp_obs());
            else passed++;
            if (i >= 1 && i <= 5) begin
                total++;
                if ({mem_ack, rep_flit_pop} !== 2'b00)
                    $display("FAIL busy_hold cyc %0d: ack/pop=%b want 00", i, {mem_ack, rep_flit_pop});
                else passed++;
            end
            if (i == 6) begin
                total++;
                if (mem_ack !== 1'b1) $display("FAIL busy_release: mem_ack=%b want 1", mem_ack);
                else passed++;
            end
            end_cycle();
        end
    endtask

    task automatic test_proto_err();
        for (int i = 0; i < 12; i++) begin
            rst = (i == 0); busy = 0; gap = 0;
            if (i == 0) begin rq.delete(); mq.delete(); end
            if (i == 1) begin
                rq.push_back({2'b01, 16'h0101});
                for (int k = 0; k < 3; k++) rq.push_back({2'b10, 16'(k)});
                rq.push_back({2'b11, 16'h0f0f});
                rq.push_back({2'b10, 16'hbbbb});
            end
            drive_inputs();
            @(negedge clk);
            model_eval();
            total++;
            if (obs() !== exp_obs())
                $display("FAIL proto cyc %0d: got %h want %h", i, obs(), exp_obs());
            else passed++;
            if (i == 6) begin
                total++;
                if ({err_proto, arb_state, rep_flit_pop} !== {1'b1, 2'b10, 1'b0})
                    $display("FAIL proto_short_tail: err=%b st=%b pop=%b want 1 10 0", err_proto, arb_state, rep_flit_pop);
                else passed++;
            end
            if (i == 8) begin
                total++;
                if (rep_flit_pop !== 1'b1) $display("FAIL proto_drop_pop: pop=%b want 1", rep_flit_pop);
                else passed++;
            end
            if (i == 9) begin
                total++;
                if (v_rep_flit_ic !== 1'b0) $display("FAIL proto_drop_fwd: v=%b want 0", v_rep_flit_ic);
                else passed++;
            end
            end_cycle();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 14; i++) begin
            rst = (i == 0 || i == 5); busy = 0; gap = 0;
            if (i == 0) begin rq.delete(); mq.delete(); end
            if (i == 1) push_good_packet(16'h4444);
            drive_inputs();
            @(negedge clk);
            model_eval();
            total++;
            if (obs() !== exp_obs())
                $display("FAIL reset_mid cyc %0d: got %h want %h", i, obs(), exp_obs());
            else passed++;
            if (i == 6) begin
                total++;
                if ({arb_state, v_mem_flits_ic, v_rep_flit_ic, rep_ctrl_ic, rep_flit_ic, err_proto, rep_flit_pop} !== {23'd0, 1'b1})
                    $display("FAIL reset_mid_clear: st=%b vrep=%b flit=%h err=%b pop=%b", arb_state, v_rep_flit_ic, rep_flit_ic, err_proto, rep_flit_pop);
                else passed++;
            end
            if (i == 7) begin
                total++;
                if (err_proto !== 1'b1) $display("FAIL reset_mid_err: err=%b want 1", err_proto);
                else passed++;
            end
            end_cycle();
        end
    endtask

    task automatic test_random();
        int len;
        for (int i = 0; i < 2500; i++) begin
            rst  = (i == 0) || ($urandom_range(0, 299) == 0);
            busy = ($urandom_range(0, 3) == 0);
            gap  = ($urandom_range(0, 3) == 0);
            if (i == 0) begin rq.delete(); mq.delete(); end
            if (rq.size() < 3) begin
                if ($urandom_range(0, 9) < 7) push_good_packet(16'($urandom));
                else begin
                    len = $urandom_range(1, 10);
                    for (int k = 0; k < len; k++) rq.push_back({2'($urandom_range(0, 3)), 16'($urandom)});
                end
            end
            if (mq.size() == 0 && $urandom_range(0, 7) == 0)
                mq.push_back({$urandom, $urandom, $urandom, $urandom});
            drive_inputs();
            @(negedge clk);
            model_eval();
            total++;
            if (obs() !== exp_obs())
                $display("FAIL random cyc %0d: got %h want %h", i, obs(), exp_obs());
            else passed++;
            end_cycle();
        end
    endtask

    initial begin
        rst = 1'b1; busy = 0; gap = 0;
        drive_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_mem_line();
        test_packet();
        test_tie();
        test_busy();
        test_proto_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
